rip_div_seq: RTL
================

RIP_DIV_SEQ -- requirements
Module: rip_div_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width.
REQ-002 Parameter CNT_WIDTH, default 6, iteration counter width; SHALL satisfy 2**CNT_WIDTH > DATA_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a divide; sampled only when busy is low.
REQ-006 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 dividend  input  DATA_WIDTH  operand a (rs1).
REQ-008 divisor  input  DATA_WIDTH  operand b (rs2).
REQ-009 flush  input  1  abort in-flight operation (pipeline kill).
REQ-010 busy  output  1  high while an operation is in flight; drives EX-stage stall.
REQ-011 done  output  1  one-cycle pulse, rslt valid.
REQ-012 rslt  output  DATA_WIDTH  registered quotient or remainder.

Function
REQ-013 FSM states SHALL be IDLE, CALC, FINAL; busy SHALL equal (state != IDLE).
REQ-014 Cycle 0 = cycle start sampled high in IDLE; op and operands SHALL be latched at end of cycle 0; later input changes SHALL have no effect.
REQ-015 Special case at latch (divisor==0, or op signed with dividend==0x80000000 and divisor==0xFFFFFFFF): IDLE->FINAL, done high in cycle 2.
REQ-016 Normal case: IDLE->CALC, CALC for exactly DATA_WIDTH cycles (1..DATA_WIDTH), FINAL in cycle DATA_WIDTH+1, done high in cycle DATA_WIDTH+2 (34 at default).
REQ-017 CALC SHALL perform restoring radix-2 division on operand magnitudes, one quotient bit per cycle, MSB first; counter SHALL count down from DATA_WIDTH-1 and exit CALC at 0.
REQ-018 Signed ops SHALL use |dividend|, |divisor|; FINAL SHALL negate quotient if operand signs differ and negate remainder if dividend negative (truncation toward zero).
REQ-019 Divisor zero: DIV/DIVU rslt = all-ones; REM/REMU rslt = dividend.
REQ-020 Signed overflow: DIV rslt = 0x80000000; REM rslt = 0.
REQ-021 FINAL SHALL register rslt, assert done, and return to IDLE; done SHALL be high exactly one cycle, in IDLE.
REQ-022 start in the done cycle SHALL be accepted (back-to-back, no bubble).
REQ-023 start while busy SHALL be ignored; no queuing.
REQ-024 flush high in any state SHALL force IDLE at the next edge; no done for the aborted op; rslt unchanged.
REQ-025 flush and start in the same IDLE cycle: flush wins, start ignored.
REQ-026 flush in the FINAL cycle SHALL suppress done and the rslt update.
REQ-027 rslt SHALL hold its value between done pulses.

Reset
REQ-028 rst_n low SHALL immediately, without clk, force state IDLE, busy 0, done 0, rslt 0, counter 0, internal operand/remainder registers 0.
REQ-029 rst_n low mid-operation SHALL abort without done; after deassertion the first accepted start behaves per REQ-014..016.

Verification
REQ-030 DIVU 100/7, start cycle 0 -> busy 1 cycles 1..33, done cycle 34, rslt 14; REMU same operands -> 2.
REQ-031 DIV 0xFFFFFFF9(-7)/2 -> rslt 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD; REM 7/-2 -> 1.
REQ-032 DIVU 5/0 -> done cycle 2, rslt 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> done cycle 2, 0x80000000; REM -> 0.
REQ-033 DIVU 100/7 then flush cycle 10 -> busy 0 cycle 11, no done, rslt retains prior value; start cycle 11 with DIVU 9/3 -> done cycle 45, rslt 3.
REQ-034 Back-to-back: start in done cycle 34 with REMU 10/4 -> done cycle 68, rslt 2; start during busy (cycle 20) -> ignored.
REQ-035 rst_n low asynchronously at cycle 15 -> busy, done, rslt 0 before next edge; no done; recovery per REQ-029.

Source files
------------

// File: rtl/rip_div_seq.sv
// rip_div_seq: sequential radix-2 restoring integer divider.
// Handles signed/unsigned quotient and remainder (DIV, DIVU, REM, REMU).
// Divide-by-zero and signed overflow skip the iteration loop and finish early.
// The FSM state is also brought out on state_dbg for observation.
//
// Handshake: start is sampled only while busy is low (state IDLE).
// A sampled start latches op and operands at that clock edge.
// done pulses for one cycle, while back in IDLE, with rslt valid.
// rslt then holds until the next done.
// flush returns the FSM to IDLE at the next edge, from any state.
// An aborted operation never raises done and never updates rslt.
module rip_div_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] rslt,
   output logic [1:0]            state_dbg
);

   localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0]  CNT_INIT = CNT_WIDTH'(DATA_WIDTH-1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CALC  = 2'b01,
      FINAL = 2'b10
   } state_t;

   state_t state, state_nxt;
   logic   done_nxt;

   // Operation context captured at acceptance.
   logic [DATA_WIDTH-1:0] quo;   // dividend magnitude shifting out, quotient shifting in
   logic [DATA_WIDTH-1:0] rem;   // partial remainder
   logic [DATA_WIDTH-1:0] dvs;   // divisor magnitude
   logic [CNT_WIDTH-1:0]  cnt;
   logic                  neg_q;
   logic                  neg_r;
   logic                  is_rem;
   logic                  div_zero;
   logic                  ovf;

   // Decode of the incoming request.
   logic                  in_signed;
   logic                  in_a_neg;
   logic                  in_b_neg;
   logic                  in_div_zero;
   logic                  in_ovf;
   logic                  in_special;
   logic [DATA_WIDTH-1:0] in_a_mag;
   logic [DATA_WIDTH-1:0] in_b_mag;
   logic                  accept;

   // One restoring step, plus the final result selection.
   logic [DATA_WIDTH:0]   shifted;
   logic [DATA_WIDTH:0]   diff;
   logic [DATA_WIDTH-1:0] final_val;

   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign accept    = (state == IDLE) && start && !flush;

   // Classify the incoming request and take operand magnitudes.
   always_comb begin
      in_signed   = ~op[0];
      in_a_neg    = in_signed & dividend[DATA_WIDTH-1];
      in_b_neg    = in_signed & divisor[DATA_WIDTH-1];
      in_div_zero = (divisor == '0);
      in_ovf      = in_signed && (dividend == MIN_NEG) && (divisor == ALL_ONES);
      in_special  = in_div_zero | in_ovf;
      in_a_mag    = in_a_neg ? -dividend : dividend;
      in_b_mag    = in_b_neg ? -divisor : divisor;
   end

   // Restoring step: shift the next dividend bit into the remainder and trial-subtract.
   always_comb begin
      shifted = {rem, quo[DATA_WIDTH-1]};
      diff    = shifted - {1'b0, dvs};
   end

   // Result selection applied in FINAL.
   // For special cases quo still holds the raw dividend.
   always_comb begin
      final_val = '0;
      if (div_zero) begin
         final_val = is_rem ? quo : ALL_ONES;
      end else if (ovf) begin
         final_val = is_rem ? '0 : quo;
      end else if (is_rem) begin
         final_val = neg_r ? -rem : rem;
      end else begin
         final_val = neg_q ? -quo : quo;
      end
   end

   // State register and the registered done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
      end
   end

   // Next-state logic. flush overrides everything.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt = in_special ? FINAL : CALC;
               end
            end
            CALC: begin
               if (cnt == '0) begin
                  state_nxt = FINAL;
               end
            end
            FINAL: begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Datapath: capture on accept, iterate in CALC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo      <= '0;
         rem      <= '0;
         dvs      <= '0;
         cnt      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         is_rem   <= 1'b0;
         div_zero <= 1'b0;
         ovf      <= 1'b0;
      end else if (accept) begin
         quo      <= in_special ? dividend : in_a_mag;
         rem      <= '0;
         dvs      <= in_b_mag;
         cnt      <= CNT_INIT;
         neg_q    <= in_a_neg ^ in_b_neg;
         neg_r    <= in_a_neg;
         is_rem   <= op[1];
         div_zero <= in_div_zero;
         ovf      <= in_ovf;
      end else if (state == CALC && !flush) begin
         if (!diff[DATA_WIDTH]) begin
            rem <= diff[DATA_WIDTH-1:0];
            quo <= {quo[DATA_WIDTH-2:0], 1'b1};
         end else begin
            rem <= shifted[DATA_WIDTH-1:0];
            quo <= {quo[DATA_WIDTH-2:0], 1'b0};
         end
         cnt <= cnt - 1'b1;
      end
   end

   // Result register: written only when FINAL completes without flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rslt <= '0;
      end else if (state == FINAL && !flush) begin
         rslt <= final_val;
      end
   end

endmodule
